bcd_cnt_arbiter: RTL and testbench

Shares one 4-bit reversible BCD counter between two requesters. Each requester submits a count job: start value, direction and step count. The block arbitrates round-robin, loads and steps the counter, and returns the final value with a done pulse. It sits in front of the BCD counter datapath as its sole sequencer; requesters never drive the counter directly.

---
 rtl/bcd_cnt_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_bcd_cnt_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_cnt_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_cnt_arbiter
//
// Sequencer that shares one reversible BCD counter between two requesters.
// Each requester posts a count job (start value, direction, step count). The
// block picks a winner round-robin while idle, loads the counter, steps it
// once per clock and reports the final value with a one-cycle done pulse.
//
// Ports
//   clk                 : clock, all state changes on the rising edge
//   res                 : asynchronous active-low reset
//   req0/req1           : job request levels, held until the matching gnt bit
//   start0/start1       : job start values (BCD digit)
//   dir0/dir1           : 0 = count up, 1 = count down
//   steps0/steps1       : number of counter steps
//   gnt                 : one-hot acknowledge, one cycle per accepted job
//   busy                : high whenever a job is in progress
//   done                : one-cycle pulse at job completion
//   done_id             : index of the requester whose job finished
//   result              : final counter value, held until the next done
//   err                 : with done, job rejected (start value out of range)
//   wrapped             : with done, counter wrapped at least once
//   Q                   : live counter value
// -----------------------------------------------------------------------------
module bcd_cnt_arbiter #(
  parameter int MAXV  = 9,
  parameter int MINV  = 0,
  parameter int STEPW = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       start0,
  input  logic [3:0]       start1,
  input  logic             dir0,
  input  logic             dir1,
  input  logic [STEPW-1:0] steps0,
  input  logic [STEPW-1:0] steps1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [3:0]       result,
  output logic             err,
  output logic             wrapped,
  output logic [3:0]       Q
);

  localparam logic [3:0] MAX_C = 4'(MAXV);
  localparam logic [3:0] MIN_C = 4'(MINV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Next counter value going up, wrapping at the upper bound.
  function automatic logic [3:0] bcd_up(input logic [3:0] q);
    if (q == MAX_C) begin
      return MIN_C;
    end else begin
      return q + 4'd1;
    end
  endfunction

  // Next counter value going down, wrapping at the lower bound.
  function automatic logic [3:0] bcd_down(input logic [3:0] q);
    if (q == MIN_C) begin
      return MAX_C;
    end else begin
      return q - 4'd1;
    end
  endfunction

  state_t           state_r;
  logic             last_r;      // requester served most recently
  logic             job_id_r;
  logic [3:0]       job_start_r;
  logic             job_dir_r;
  logic [STEPW-1:0] job_steps_r;
  logic [STEPW-1:0] rem_r;
  logic             wrap_r;

  logic             any_req_s;
  logic             win_s;
  logic [3:0]       sel_start_s;
  logic             sel_dir_s;
  logic [STEPW-1:0] sel_steps_s;
  logic             at_edge_s;

  // Round-robin winner: a tie goes to the requester not served last.
  always_comb begin
    any_req_s = req0 | req1;
    if (req0 && req1) begin
      win_s = ~last_r;
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Job fields of the current winner.
  always_comb begin
    if (win_s) begin
      sel_start_s = start1;
      sel_dir_s   = dir1;
      sel_steps_s = steps1;
    end else begin
      sel_start_s = start0;
      sel_dir_s   = dir0;
      sel_steps_s = steps0;
    end
  end

  // Counter sits on the wrap boundary for the latched direction.
  always_comb begin
    if (job_dir_r) begin
      at_edge_s = (Q == MIN_C);
    end else begin
      at_edge_s = (Q == MAX_C);
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_r     <= IDLE;
      last_r      <= 1'b1;
      job_id_r    <= 1'b0;
      job_start_r <= 4'd0;
      job_dir_r   <= 1'b0;
      job_steps_r <= {STEPW{1'b0}};
      rem_r       <= {STEPW{1'b0}};
      wrap_r      <= 1'b0;
      gnt         <= 2'b00;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= 1'b0;
      result      <= 4'd0;
      err         <= 1'b0;
      wrapped     <= 1'b0;
      Q           <= 4'd0;
    end else begin
      // Pulse outputs default low; the states below raise them for one cycle.
      gnt     <= 2'b00;
      done    <= 1'b0;
      err     <= 1'b0;
      wrapped <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            job_id_r    <= win_s;
            job_start_r <= sel_start_s;
            job_dir_r   <= sel_dir_s;
            job_steps_r <= sel_steps_s;
            last_r      <= win_s;
            gnt         <= win_s ? 2'b10 : 2'b01;
            busy        <= 1'b1;
            state_r     <= LOAD;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        LOAD: begin
          if (job_start_r > MAX_C) begin
            // Rejected job: the counter is left untouched.
            done    <= 1'b1;
            done_id <= job_id_r;
            result  <= 4'd0;
            err     <= 1'b1;
            wrapped <= 1'b0;
            state_r <= DONE;
          end else begin
            Q       <= job_start_r;
            rem_r   <= job_steps_r;
            wrap_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        RUN: begin
          if (rem_r == {STEPW{1'b0}}) begin
            done    <= 1'b1;
            done_id <= job_id_r;
            result  <= Q;
            wrapped <= wrap_r;
            state_r <= DONE;
          end else begin
            if (job_dir_r) begin
              Q <= bcd_down(Q);
            end else begin
              Q <= bcd_up(Q);
            end
            if (at_edge_s) begin
              wrap_r <= 1'b1;
            end else begin
              wrap_r <= wrap_r;
            end
            rem_r   <= rem_r - {{(STEPW-1){1'b0}}, 1'b1};
            state_r <= RUN;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_cnt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bcd_cnt_arbiter
//
// Directed and randomized jobs against bcd_cnt_arbiter. Expected values come
// from a modular-arithmetic model of the BCD counter and a round-robin model
// of the arbiter kept in this bench.
// -----------------------------------------------------------------------------
module tb_bcd_cnt_arbiter;

  localparam int MAXV  = 9;
  localparam int MINV  = 0;
  localparam int STEPW = 4;
  localparam int RANGE = MAXV - MINV + 1;

  logic             clk;
  logic             res;
  logic             req0, req1;
  logic [3:0]       start0, start1;
  logic             dir0, dir1;
  logic [STEPW-1:0] steps0, steps1;
  logic [1:0]       gnt;
  logic             busy, done, done_id, err, wrapped;
  logic [3:0]       result, Q;

  int checks   = 0;
  int failures = 0;
  int last_srv = 1;   // model: requester served last (1 after reset -> 0 wins tie)
  int q_model  = 0;   // model: counter value between jobs

  bcd_cnt_arbiter #(.MAXV(MAXV), .MINV(MINV), .STEPW(STEPW)) dut (
    .clk(clk), .res(res),
    .req0(req0), .req1(req1),
    .start0(start0), .start1(start1),
    .dir0(dir0), .dir1(dir1),
    .steps0(steps0), .steps1(steps1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .result(result), .err(err), .wrapped(wrapped), .Q(Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter value after k steps from start, by modular arithmetic.
  function automatic int model_val(input int st, input int d, input int k);
    int off;
    off = st - MINV;
    if (d == 0) return MINV + ((off + k) % RANGE);
    else        return MINV + ((((off - k) % RANGE) + RANGE) % RANGE);
  endfunction

  // Whether k steps from start cross the wrap boundary at least once.
  function automatic bit model_wrap(input int st, input int d, input int k);
    if (d == 0) return (st - MINV + k) >= RANGE;
    else        return k > (st - MINV);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("rst_Q", {4'd0, Q}, 8'd0);
    chk("rst_result", {4'd0, result}, 8'd0);
    chk("rst_gnt", {6'd0, gnt}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_done_id", {7'd0, done_id}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    chk("rst_wrapped", {7'd0, wrapped}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    res = 1'b1;
    last_srv = 1;
    q_model  = 0;
  endtask

  // Runs one job starting at a negedge with requests already set up.
  // drop: release the winner's req after gnt. mutate: scramble the winner's
  // inputs and drop its req during the job.
  task automatic run_job(input bit drop, input bit mutate);
    int id, st, d, n, fin;
    bit wr;
    if (req0 && req1) id = 1 - last_srv;
    else if (req1)    id = 1;
    else              id = 0;
    st = (id == 1) ? int'(start1) : int'(start0);
    d  = (id == 1) ? int'(dir1)   : int'(dir0);
    n  = (id == 1) ? int'(steps1) : int'(steps0);
    last_srv = id;
    @(negedge clk);  // after E0
    chk("gnt", {6'd0, gnt}, (id == 1) ? 8'd2 : 8'd1);
    chk("busy_e0", {7'd0, busy}, 8'd1);
    if (drop) begin
      if (id == 1) req1 = 1'b0; else req0 = 1'b0;
    end
    if (st > MAXV) begin
      @(negedge clk);  // after E1
      chk("err_done", {7'd0, done}, 8'd1);
      chk("err_err", {7'd0, err}, 8'd1);
      chk("err_result", {4'd0, result}, 8'd0);
      chk("err_wrapped", {7'd0, wrapped}, 8'd0);
      chk("err_done_id", 8'(id), {7'd0, done_id});
      chk("err_Q", {4'd0, Q}, 8'(q_model));
    end else begin
      @(negedge clk);  // after E1
      chk("load_Q", {4'd0, Q}, 8'(st));
      chk("load_gnt", {6'd0, gnt}, 8'd0);
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        if (mutate && k == 1) begin
          if (id == 1) begin
            start1 = 4'(st + 3); dir1 = ~dir1; steps1 = 4'd1; req1 = 1'b0;
          end else begin
            start0 = 4'(st + 3); dir0 = ~dir0; steps0 = 4'd1; req0 = 1'b0;
          end
        end
        chk("step_Q", {4'd0, Q}, 8'(model_val(st, d, k)));
        chk("step_done", {7'd0, done}, 8'd0);
        chk("step_busy", {7'd0, busy}, 8'd1);
      end
      fin = model_val(st, d, n);
      wr  = model_wrap(st, d, n);
      @(negedge clk);  // after E(N+2)
      chk("done", {7'd0, done}, 8'd1);
      chk("result", {4'd0, result}, 8'(fin));
      chk("wrapped", {7'd0, wrapped}, {7'd0, wr});
      chk("err", {7'd0, err}, 8'd0);
      chk("done_id", {7'd0, done_id}, 8'(id));
      chk("done_busy", {7'd0, busy}, 8'd1);
      q_model = fin;
    end
    @(negedge clk);  // back in IDLE
    chk("idle_done", {7'd0, done}, 8'd0);
    chk("idle_busy", {7'd0, busy}, 8'd0);
    chk("idle_Q", {4'd0, Q}, 8'(q_model));
  endtask

  initial begin
    res = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    start0 = 4'd0; start1 = 4'd0;
    dir0 = 1'b0; dir1 = 1'b0;
    steps0 = 4'd0; steps1 = 4'd0;
    #2;
    do_reset();

    // Basic up job from requester 0.
    req0 = 1'b1; start0 = 4'd3; dir0 = 1'b0; steps0 = 4'd4;
    run_job(1'b1, 1'b0);

    // Up wrap and down wrap from requester 1.
    req1 = 1'b1; start1 = 4'd8; dir1 = 1'b0; steps1 = 4'd3;
    run_job(1'b1, 1'b0);
    req1 = 1'b1; start1 = 4'd1; dir1 = 1'b1; steps1 = 4'd3;
    run_job(1'b1, 1'b0);

    // Both held for three jobs: order 0,1,0.
    req0 = 1'b1; start0 = 4'd2; dir0 = 1'b0; steps0 = 4'd2;
    req1 = 1'b1; start1 = 4'd7; dir1 = 1'b1; steps1 = 4'd2;
    run_job(1'b0, 1'b0);
    run_job(1'b0, 1'b0);
    run_job(1'b0, 1'b0);
    req0 = 1'b0; req1 = 1'b0;

    // After reset, a tie goes to requester 0.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    run_job(1'b1, 1'b0);
    run_job(1'b1, 1'b0);

    // Rejected start value and zero-step job.
    req0 = 1'b1; start0 = 4'd12; dir0 = 1'b0; steps0 = 4'd3;
    run_job(1'b1, 1'b0);
    req0 = 1'b1; start0 = 4'd5; dir0 = 1'b1; steps0 = 4'd0;
    run_job(1'b1, 1'b0);

    // Reset in the middle of a 9-step job.
    req0 = 1'b1; start0 = 4'd4; dir0 = 1'b0; steps0 = 4'd9;
    @(negedge clk);
    chk("mid_gnt", {6'd0, gnt}, 8'd1);
    req0 = 1'b0;
    @(negedge clk);
    chk("mid_load_Q", {4'd0, Q}, 8'd4);
    @(negedge clk);
    @(negedge clk);
    chk("mid_run_Q", {4'd0, Q}, 8'd6);
    res = 1'b0;
    #1;
    chk("mid_rst_Q", {4'd0, Q}, 8'd0);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_done", {7'd0, done}, 8'd0);
    end
    res = 1'b1;
    last_srv = 1;
    q_model  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_done", {7'd0, done}, 8'd0);
    end
    req1 = 1'b1; start1 = 4'd6; dir1 = 1'b1; steps1 = 4'd2;
    run_job(1'b1, 1'b0);

    // Inputs scrambled and req dropped mid-job.
    req0 = 1'b1; start0 = 4'd2; dir0 = 1'b0; steps0 = 4'd5;
    run_job(1'b0, 1'b1);

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      if (!req0 && $urandom_range(0, 1) == 1) begin
        req0 = 1'b1; start0 = 4'($urandom_range(0, 15));
        dir0 = 1'($urandom_range(0, 1)); steps0 = 4'($urandom_range(0, 15));
      end
      if (!req1 && $urandom_range(0, 1) == 1) begin
        req1 = 1'b1; start1 = 4'($urandom_range(0, 15));
        dir1 = 1'($urandom_range(0, 1)); steps1 = 4'($urandom_range(0, 15));
      end
      if (!req0 && !req1) begin
        req0 = 1'b1; start0 = 4'($urandom_range(0, 15));
        dir0 = 1'($urandom_range(0, 1)); steps0 = 4'($urandom_range(0, 15));
      end
      run_job(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
